// File: rtl/kv_cache_controller.sv
// rtl/kv_cache_controller.sv - key-value front-end with a direct-mapped write-through cache
// Optional hit/miss counters are enabled by defining KV_CACHE_STATS_EN.
module kv_cache_controller #(
    parameter int WIDTH       = 32,
    parameter int VALUE_SIZE  = 32,
    parameter int CACHE_LINES = 16,
    parameter int EXT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [WIDTH-1:0]      req_key,
    input  logic [VALUE_SIZE-1:0] req_value,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [VALUE_SIZE-1:0] resp_value,
    output logic                  resp_hit,
    output logic                  resp_success,
    output logic [1:0]            ext_operation,
    output logic [WIDTH-1:0]      ext_key,
    output logic [VALUE_SIZE-1:0] ext_value_in,
    input  logic [VALUE_SIZE-1:0] ext_value_out,
    input  logic                  ext_hit,
    input  logic                  ext_success,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam logic [15:0] LAT_INIT = 16'(EXT_LATENCY);
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EXT_ISSUE, S_EXT_WAIT, S_RESP} state_t;
    state_t state, next_state;

    logic [1:0]            op_q;
    logic [WIDTH-1:0]      key_q;
    logic [VALUE_SIZE-1:0] value_q;
    logic [15:0]           wait_cnt;
    logic [CACHE_LINES-1:0] line_valid;
    logic [WIDTH-1:0]      line_key   [CACHE_LINES];
    logic [VALUE_SIZE-1:0] line_value [CACHE_LINES];

    logic [IDX_W-1:0]      idx;
    logic                  tag_hit;
    logic                  wait_done;
    logic                  fill_en;
    logic [VALUE_SIZE-1:0] fill_value;

    assign idx        = key_q[IDX_W-1:0];
    assign tag_hit    = line_valid[idx] && (line_key[idx] == key_q);
    assign wait_done  = (wait_cnt == 16'd1);
    // Lookups that hit externally and successful inserts both (re)write the line.
    assign fill_en    = (state == S_EXT_WAIT) && wait_done &&
                        (((op_q == OP_LOOKUP) && ext_hit) || ((op_q == OP_INSERT) && ext_success));
    assign fill_value = (op_q == OP_LOOKUP) ? ext_value_out : value_q;
    assign ext_key      = key_q;
    assign ext_value_in = value_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (req_valid) next_state = S_CHECK;
            S_CHECK:     if ((op_q == OP_NOP) || ((op_q == OP_LOOKUP) && tag_hit))
                             next_state = S_RESP;
                         else
                             next_state = S_EXT_ISSUE;
            S_EXT_ISSUE: next_state = S_EXT_WAIT;
            S_EXT_WAIT:  if (wait_done) next_state = S_RESP;
            S_RESP:      if (resp_ready) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == S_IDLE) && !reset;
        resp_valid    = (state == S_RESP);
        ext_operation = (state == S_EXT_ISSUE) ? op_q : OP_NOP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= OP_NOP;
            key_q        <= '0;
            value_q      <= '0;
            wait_cnt     <= '0;
            line_valid   <= '0;
            resp_value   <= '0;
            resp_hit     <= 1'b0;
            resp_success <= 1'b0;
        end else begin
            if ((state == S_IDLE) && req_valid) begin
                op_q    <= req_op;
                key_q   <= req_key;
                value_q <= req_value;
            end
            if (state == S_CHECK) begin
                if ((op_q == OP_DELETE) && tag_hit) line_valid[idx] <= 1'b0;
                resp_hit     <= (op_q == OP_LOOKUP);
                resp_value   <= (op_q == OP_LOOKUP) ? line_value[idx] : '0;
                resp_success <= 1'b0;
            end
            if (state == S_EXT_ISSUE) wait_cnt <= LAT_INIT;
            if (state == S_EXT_WAIT) begin
                wait_cnt <= wait_cnt - 16'd1;
                if (wait_done) begin
                    resp_hit     <= (op_q == OP_LOOKUP) && ext_hit;
                    resp_value   <= ((op_q == OP_LOOKUP) && ext_hit) ? ext_value_out : '0;
                    resp_success <= (op_q != OP_LOOKUP) && ext_success;
                end
            end
            if (fill_en) line_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_key[idx]   <= key_q;
            line_value[idx] <= fill_value;
        end
    end

`ifdef KV_CACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if ((state == S_CHECK) && (op_q == OP_LOOKUP)) begin
            if (tag_hit && (hit_q != 32'hFFFF_FFFF))   hit_q  <= hit_q + 32'd1;
            if (!tag_hit && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_kv_cache_controller.sv
// tb/tb_kv_cache_controller.sv - directed self-checking bench for kv_cache_controller
module tb_kv_cache_controller;
`ifdef KV_CACHE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_key;
    logic [31:0] req_value;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_value;
    logic        resp_hit;
    logic        resp_success;
    logic [1:0]  ext_operation;
    logic [31:0] ext_key;
    logic [31:0] ext_value_in;
    logic [31:0] ext_value_out = 32'd0;
    logic        ext_hit = 1'b0;
    logic        ext_success = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks_total = 0;
    int checks_passed = 0;
    int ext_ops = 0;
    logic [31:0] last_ext_key = 32'd0;
    logic [31:0] mem [logic [31:0]];

    int          r_lat;
    int          r_ext;
    logic        r_hit;
    logic        r_succ;
    logic [31:0] r_value;

    kv_cache_controller dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_value(resp_value),
        .resp_hit(resp_hit), .resp_success(resp_success),
        .ext_operation(ext_operation), .ext_key(ext_key), .ext_value_in(ext_value_in),
        .ext_value_out(ext_value_out), .ext_hit(ext_hit), .ext_success(ext_success),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // External memory: sees the one-cycle issue pulse mid-cycle and holds its answer.
    always @(negedge clk) begin
        if (ext_operation != 2'b11) begin
            ext_ops      = ext_ops + 1;
            last_ext_key = ext_key;
            case (ext_operation)
                2'b00: begin
                    ext_hit       = mem.exists(ext_key);
                    ext_value_out = ext_hit ? mem[ext_key] : 32'd0;
                    ext_success   = 1'b0;
                end
                2'b01: begin
                    mem[ext_key] = ext_value_in;
                    ext_hit      = 1'b0;
                    ext_success  = 1'b1;
                end
                default: begin
                    ext_success = mem.exists(ext_key);
                    if (ext_success) mem.delete(ext_key);
                    ext_hit = 1'b0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total = checks_total + 1;
        if (got === exp) checks_passed = checks_passed + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_req(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val);
        int n0;
        int guard;
        n0 = ext_ops;
        @(negedge clk);
        req_op = op; req_key = key; req_value = val; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 1;
        while (!resp_valid && r_lat < 100) begin
            @(posedge clk);
            #1 r_lat++;
        end
        if (!resp_valid) check("resp_timeout", 0, 1);
        r_hit = resp_hit; r_succ = resp_success; r_value = resp_value;
        @(posedge clk);
        #1 r_ext = ext_ops - n0;
    endtask

    task automatic check_resp(input string tag, input int lat, input logic hit,
                              input logic succ, input logic [31:0] val, input int ext_n);
        check({tag, "_lat"}, 64'(r_lat), 64'(lat));
        check({tag, "_hit"}, 64'(r_hit), 64'(hit));
        check({tag, "_succ"}, 64'(r_succ), 64'(succ));
        check({tag, "_value"}, 64'(r_value), 64'(val));
        check({tag, "_ext"}, 64'(r_ext), 64'(ext_n));
    endtask

    initial begin
        int bad;
        logic [31:0] held_value;
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b11; req_key = '0; req_value = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        check("rst_ext_op", 64'(ext_operation), 64'h3);
        check("rst_ext_key", 64'(ext_key), 0);
        check("rst_resp_value", 64'(resp_value), 0);
        check("rst_hit_count", 64'(hit_count), 0);
        @(negedge clk) reset = 1'b0;
        #1 check("post_rst_req_ready", 64'(req_ready), 1);

        run_req(2'b00, 32'h5, 32'h0);
        check_resp("lookup_empty", 4, 0, 0, 32'h0, 1);
        check("lookup_empty_extkey", 64'(last_ext_key), 64'h5);

        run_req(2'b01, 32'h5, 32'hDEAD);
        check_resp("insert5", 4, 0, 1, 32'h0, 1);

        run_req(2'b00, 32'h5, 32'h0);
        check_resp("lookup5_cached", 2, 1, 0, 32'hDEAD, 0);
        check("hit_count_1", 64'(hit_count), 64'(STATS));

        run_req(2'b01, 32'h15, 32'hBEEF);
        check_resp("insert15", 4, 0, 1, 32'h0, 1);

        run_req(2'b00, 32'h5, 32'h0);
        check_resp("lookup5_evicted", 4, 1, 0, 32'hDEAD, 1);
        check("miss_count_2", 64'(miss_count), 64'(2 * STATS));

        run_req(2'b00, 32'h5, 32'h0);
        check_resp("lookup5_refilled", 2, 1, 0, 32'hDEAD, 0);

        run_req(2'b11, 32'h5, 32'h0);
        check_resp("nop", 2, 0, 0, 32'h0, 0);

        run_req(2'b10, 32'h5, 32'h0);
        check_resp("delete5", 4, 0, 1, 32'h0, 1);
        run_req(2'b00, 32'h5, 32'h0);
        check_resp("lookup5_deleted", 4, 0, 0, 32'h0, 1);

        run_req(2'b10, 32'h77, 32'h0);
        check_resp("delete_missing", 4, 0, 0, 32'h0, 1);

        run_req(2'b01, 32'h15, 32'hCAFE);
        run_req(2'b00, 32'h15, 32'h0);
        check_resp("lookup15_newest", 2, 1, 0, 32'hCAFE, 0);

        // Back-pressured response must hold still.
        run_req(2'b01, 32'h3, 32'h1234);
        resp_ready = 1'b0;
        @(negedge clk);
        req_op = 2'b00; req_key = 32'h3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 held_value = resp_value;
        check("stall_first_value", 64'(held_value), 64'h1234);
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!resp_valid || !resp_hit || resp_success || resp_value != held_value || req_ready) bad++;
        end
        check("stall_stable_cycles", 64'(bad), 0);
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1 check("stall_released", 64'(resp_valid), 0);
        check("stall_req_ready", 64'(req_ready), 1);

        // Reset during EXT_WAIT of a lookup miss.
        run_req(2'b01, 32'h7, 32'h77);
        @(negedge clk);
        req_op = 2'b00; req_key = 32'h9; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_resp_valid", 64'(resp_valid), 0);
        check("midrst_ext_op", 64'(ext_operation), 64'h3);
        check("midrst_req_ready", 64'(req_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 check("midrst_ready_after", 64'(req_ready), 1);
        bad = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (resp_valid) bad++;
        end
        check("midrst_no_resp", 64'(bad), 0);
        check("midrst_hit_count", 64'(hit_count), 0);
        run_req(2'b00, 32'h7, 32'h0);
        check_resp("lookup7_after_rst", 4, 1, 0, 32'h77, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/kv_cache_controller.md
Name: kv_cache_controller

Overview:
- Front-end for the external key-value memory: accepts lookup/insert/delete requests over a valid/ready handshake.
- Serves lookup hits from a small direct-mapped on-chip cache.
- Forwards misses, inserts and deletes to the external memory port with write-through semantics.
- Sits directly upstream of the external memory; one request in flight at a time.

Parameters:
- WIDTH, 32, key width in bits
- VALUE_SIZE, 32, value width in bits
- CACHE_LINES, 16, direct-mapped line count; power of two, >= 2
- EXT_LATENCY, 1, cycles after the ext issue cycle before ext_hit/ext_success/ext_value_out are sampled; >= 1

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_op  input  2  00 lookup, 01 insert, 10 delete, 11 no-op
- req_key  input  WIDTH  request key
- req_value  input  VALUE_SIZE  insert value
- resp_valid  output  1  response present; held until resp_ready
- resp_ready  input  1  consumer accepts response
- resp_value  output  VALUE_SIZE  lookup result; 0 on miss and for non-lookup ops
- resp_hit  output  1  lookup found the key (cache or external)
- resp_success  output  1  insert/delete succeeded
- ext_operation  output  2  to external memory; 11 = idle
- ext_key  output  WIDTH  to external memory
- ext_value_in  output  VALUE_SIZE  to external memory
- ext_value_out  input  VALUE_SIZE  from external memory
- ext_hit  input  1  from external memory
- ext_success  input  1  from external memory
- hit_count  output  32  cache-hit counter; see Optional Feature
- miss_count  output  32  cache-miss counter; see Optional Feature

Behaviour:
- Reset (async): state IDLE; all line valid bits 0; req_ready 0 during reset, 1 afterwards; resp_valid 0; resp_value 0; resp_hit 0; resp_success 0; ext_operation 11; ext_key 0; ext_value_in 0; counters 0.
- Cache line: valid bit, full WIDTH-bit stored key, value. Index is req_key[log2(CACHE_LINES)-1:0]; a hit requires valid and stored key == request key.
- States: IDLE, CHECK, EXT_ISSUE, EXT_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/key/value and go to CHECK.
- CHECK (req_ready=0):
  - op 11 -> RESP with hit=0, success=0.
  - Lookup with tag hit -> RESP, hit=1, value from line.
  - Lookup miss -> EXT_ISSUE.
  - Insert -> EXT_ISSUE.
  - Delete -> invalidate the line if its tag matches, then EXT_ISSUE.
- EXT_ISSUE:
  - ext_operation=latched op, ext_key/ext_value_in driven, for exactly one cycle.
  - Go to EXT_WAIT; the wait counter loads EXT_LATENCY.
- EXT_WAIT:
  - ext_operation=11; decrement the counter; at 0, sample the ext inputs and go to RESP.
  - Lookup: if ext_hit=1, fill the line (key, ext_value_out, valid=1), overwriting any victim; resp_hit=ext_hit; resp_value=ext_value_out if hit, else 0.
  - Insert: resp_success=ext_success; on success, write the line (overwrite).
  - Delete: resp_success=ext_success.
  - resp_hit=0 for insert/delete; resp_success=0 for lookup.
- RESP:
  - resp_valid=1 with stable fields until resp_valid&&resp_ready, then IDLE.
  - Next request accepted at the earliest one cycle after the response handshake.
- Latency from accept edge to resp_valid:
  - Cache hit: 2 cycles.
  - External op: 3+EXT_LATENCY cycles.
  - No-op: 2 cycles.
- ext_operation is 11 in every state except EXT_ISSUE.
- The external memory enforces no duplicate keys; an insert of an existing key leaves the cache holding the newest value.
- Reset mid-operation: abort, return to IDLE, no response produced, cache invalidated.
- req_valid while not in IDLE is ignored. The requester holds the request until req_ready.

Optional Feature:
- Macro: KV_CACHE_STATS_EN.
- Defined: hit_count increments on each lookup served in CHECK by a tag hit. miss_count increments on each lookup forwarded to the external memory. Both saturate at 2^32-1 and are cleared by reset.
- Undefined: no counter registers; hit_count and miss_count are tied to 0.

Test Plan:
- After reset, lookup key 0x5 -> ext_operation=00 pulsed once; with the external memory empty, response hit=0, value=0, success=0.
- Insert key 0x5 value 0xDEAD -> ext insert pulsed; response success=1. Then lookup 0x5 -> response in 2 cycles, hit=1, value=0xDEAD, no ext_operation activity, hit_count=1 (stats enabled).
- Insert 0x15 value 0xBEEF (same index as 0x5 with 16 lines), then lookup 0x5 -> cache miss, external hit, value 0xDEAD, line refilled; miss_count increments.
- Delete 0x5 -> success=1; lookup 0x5 -> ext lookup issued, hit=0.
- Hold resp_ready=0 for 5 cycles -> resp_valid and fields stable; req_ready=0 throughout; completes on resp_ready=1.
- Assert reset during EXT_WAIT of a lookup -> no resp_valid, ext_operation=11, req_ready=1 after release, earlier cached keys miss.
